// File: rtl/n64_unlock_writer.sv
// Issues the four-word unlock sequence (or a single relock write) to the configuration lock
// register over a simple write/ack bus, then checks the returned unlock status.
module n64_unlock_writer #(
  parameter logic [16:0] BASE_ADDRESS = 17'h10000,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_unlock,
  input  logic        start_lock,
  input  logic        abort,
  output logic        bus_write,
  output logic [16:0] bus_address,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        cfg_unlock,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StGap,
    StCheck,
    StFinish
  } state_e;

  localparam logic [3:0] GapLast = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [7:0] AckLast = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        lock_q, lock_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        chk_cnt_q, chk_cnt_d;
  logic        err_q, err_d;

  logic        last_word;
  logic [15:0] cur_word;

  function automatic logic [15:0] unlock_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = 16'h5F55;
      2'd1:    w = 16'h4E4C;
      2'd2:    w = 16'h4F43;
      default: w = 16'h4B5F;
    endcase
    return w;
  endfunction

  always_comb begin
    last_word = lock_q || (idx_q == 2'd3);
    cur_word  = lock_q ? 16'h0000 : unlock_word(idx_q);
  end

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    idx_d     = idx_q;
    ack_cnt_d = ack_cnt_q;
    gap_cnt_d = gap_cnt_q;
    chk_cnt_d = chk_cnt_q;
    err_d     = err_q;

    if (abort) begin
      // Abort wins over everything, including a start in the same cycle; no done/error pulse.
      state_d   = StIdle;
      idx_d     = 2'd0;
      ack_cnt_d = 8'd0;
      gap_cnt_d = 4'd0;
      chk_cnt_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_lock || start_unlock) begin
            state_d   = StWrite;
            lock_d    = start_lock;
            idx_d     = 2'd0;
            ack_cnt_d = 8'd0;
            err_d     = 1'b0;
          end
        end
        StWrite: begin
          if (bus_ack) begin
            ack_cnt_d = 8'd0;
            if (last_word) begin
              state_d   = StCheck;
              chk_cnt_d = 1'b0;
            end else begin
              idx_d = idx_q + 2'd1;
              if (GAP_CYCLES == 0) begin
                state_d = StWrite;
              end else begin
                state_d   = StGap;
                gap_cnt_d = 4'd0;
              end
            end
          end else if (ack_cnt_q == AckLast) begin
            state_d = StFinish;
            err_d   = 1'b1;
          end else begin
            ack_cnt_d = ack_cnt_q + 8'd1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_d   = StWrite;
            ack_cnt_d = 8'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
        StCheck: begin
          if (chk_cnt_q) begin
            state_d = StFinish;
            // Unlock expects status 1, lock expects 0: a mismatch is status equal to lock mode.
            if (cfg_unlock == lock_q) err_d = 1'b1;
          end else begin
            chk_cnt_d = 1'b1;
          end
        end
        StFinish: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      lock_q    <= 1'b0;
      idx_q     <= 2'd0;
      ack_cnt_q <= 8'd0;
      gap_cnt_q <= 4'd0;
      chk_cnt_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      idx_q     <= idx_d;
      ack_cnt_q <= ack_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      chk_cnt_q <= chk_cnt_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode straight from registered state, so address/data cannot move mid-request.
  always_comb begin
    busy        = (state_q != StIdle);
    bus_write   = (state_q == StWrite);
    bus_address = BASE_ADDRESS;
    bus_wdata   = bus_write ? cur_word : 16'h0000;
    done        = (state_q == StFinish);
    error       = done && err_q;
  end

endmodule

// File: doc/n64_unlock_writer.md
N64_UNLOCK_WRITER -- requirements
Module: n64_unlock_writer

Interface
REQ-001 Parameter BASE_ADDRESS, default 17'h10000: register-bus word address of the configuration lock register.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted between consecutive bus writes; legal range 0..15.
REQ-003 Parameter ACK_TIMEOUT, default 255: maximum cycles a write waits for acknowledge; legal range 1..255.
REQ-004 Port: clk, input, 1, sole clock; all logic on posedge clk.
REQ-005 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port: start_unlock, input, 1, single-cycle request to issue the unlock sequence.
REQ-007 Port: start_lock, input, 1, single-cycle request to issue a relock write.
REQ-008 Port: abort, input, 1, console reset/NMI; cancels any operation in flight.
REQ-009 Port: bus_write, output, 1, write request; held high until acknowledged.
REQ-010 Port: bus_address, output, 17, write address.
REQ-011 Port: bus_wdata, output, 16, write data.
REQ-012 Port: bus_ack, input, 1, write accepted in the cycle where bus_write and bus_ack are both high.
REQ-013 Port: cfg_unlock, input, 1, current unlock status returned by the lock register.
REQ-014 Port: busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 Port: done, output, 1, one-cycle pulse when an operation completes (pass or fail).
REQ-016 Port: error, output, 1, one-cycle pulse coincident with done on timeout or status mismatch.

Function
REQ-017 FSM states: IDLE, WRITE, GAP, CHECK, FINISH.
REQ-018 Unlock sequence: four writes, in order, of data 16'h5F55, 16'h4E4C, 16'h4F43, 16'h4B5F, all to BASE_ADDRESS.
REQ-019 Lock operation: one write of data 16'h0000 to BASE_ADDRESS.
REQ-020 IDLE: start_lock high -> WRITE in lock mode; else start_unlock high -> WRITE in unlock mode with word index 0; both high in the same cycle -> lock wins.
REQ-021 start_unlock/start_lock arriving while busy are ignored and are not queued.
REQ-022 WRITE: bus_write high, bus_address = BASE_ADDRESS, bus_wdata = current word; bus_address/bus_wdata stable for as long as bus_write is high.
REQ-023 WRITE, bus_ack high: bus_write drops the next cycle; more words pending -> word index +1, go to GAP (or directly to WRITE when GAP_CYCLES = 0); last word -> CHECK.
REQ-024 GAP: bus_write low for exactly GAP_CYCLES cycles, then WRITE.
REQ-025 Ack timeout: an 8-bit counter clears on entry to WRITE and increments each WRITE cycle without bus_ack; on reaching ACK_TIMEOUT, drop bus_write, set the error flag, go to FINISH.
REQ-026 CHECK: lasts exactly 2 cycles, then samples cfg_unlock; unlock mode expects 1, lock mode expects 0; mismatch sets the error flag; go to FINISH.
REQ-027 FINISH: done = 1 and error = error flag for one cycle, then IDLE; busy drops in the same cycle as the IDLE entry.
REQ-028 Write count: unlock = exactly 4 bus handshakes, lock = exactly 1; a handshake is never issued in GAP, CHECK, FINISH or IDLE.
REQ-029 abort high in any state: the next cycle is IDLE with bus_write = 0; done and error are not pulsed; a start in the same cycle as abort is ignored.
REQ-030 bus_ack while bus_write is low is ignored.

Reset
REQ-031 reset_n low asynchronously forces IDLE, with busy, done, error and bus_write = 0, bus_wdata = 16'h0000, bus_address = BASE_ADDRESS, and all counters cleared.
REQ-032 After reset_n deasserts, the first start is accepted no earlier than the first posedge on which reset_n is sampled high.

Verification
REQ-033 start_unlock, bus_ack tied high, cfg_unlock rises after the 4th write -> writes 5F55, 4E4C, 4F43, 4B5F at 17'h10000, 2 idle cycles between writes, done=1 with error=0.
REQ-034 start_lock with cfg_unlock = 0 -> one write of 16'h0000, done=1 with error=0; repeat with cfg_unlock stuck at 1 -> done=1 with error=1.
REQ-035 start_unlock, bus_ack never asserted -> bus_write high for 255 cycles, then drops, done=1 with error=1, no further writes.
REQ-036 bus_ack delayed 5 cycles on the 2nd word -> bus_wdata holds 16'h4E4C throughout the wait, and the sequence completes normally.
REQ-037 abort asserted during the 3rd write -> bus_write = 0 the next cycle, busy = 0, no done pulse; a following start_unlock restarts from 16'h5F55.
REQ-038 start_unlock and start_lock in the same cycle, and a start while busy -> lock executes, and the mid-operation start causes no extra writes.
